// File: rtl/ram_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl_if : request/response bus between requester and controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ram_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl : sequences timed write strobes and read waits to a 4-byte RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_access_ctrl #(
  parameter int WR_PULSE   = 2,
  parameter int RD_WAIT    = 2,
  parameter int CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clear,
  ram_access_ctrl_if.slave bus,
  output logic             ram_clear_n,
  output logic             ram_read,
  output logic [1:0]       ram_sel,
  output logic [7:0]       ram_wdata,
  input  logic [7:0]       ram_rdata
);

  localparam logic [3:0] c_wr_load  = 4'(WR_PULSE - 1);
  localparam logic [3:0] c_rd_load  = 4'(RD_WAIT - 1);
  localparam logic [3:0] c_clr_load = 4'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    WSET   = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4,
    RWAIT  = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_written;
  logic       r_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  // ram_sel doubles as the registered request address for both paths.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= INIT;
      r_cnt       <= c_clr_load;
      r_written   <= 4'b0000;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      ram_clear_n <= 1'b0;
      ram_read    <= 1'b1;
      ram_sel     <= 2'b00;
      ram_wdata   <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= IDLE;
            ram_clear_n <= 1'b1;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_ready <= 1'b0;
            ram_sel <= bus.req_addr;
            if (bus.req_we) begin
              ram_wdata <= bus.req_wdata;
              r_state   <= WSET;
            end else begin
              r_cnt   <= c_rd_load;
              r_state <= RWAIT;
            end
          end
        end
        WSET: begin
          ram_read <= 1'b0;
          r_cnt    <= c_wr_load;
          r_state  <= WPULSE;
        end
        WPULSE: begin
          if (r_cnt == 4'd0) begin
            ram_read           <= 1'b1;
            r_written[ram_sel] <= 1'b1;
            r_state            <= WHOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WHOLD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= 8'h00;
          r_rsp_err   <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        RWAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ram_rdata;
            r_rsp_err   <= ~r_written[ram_sel];
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= INIT;
          r_cnt       <= c_clr_load;
          r_ready     <= 1'b0;
          ram_clear_n <= 1'b0;
          ram_read    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_access_ctrl : random request stream checked against a RAM-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_access_ctrl;
  localparam int WR_PULSE   = 2;
  localparam int RD_WAIT    = 2;
  localparam int CLR_CYCLES = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic       ram_clear_n, ram_read;
  logic [1:0] ram_sel;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] ram_mem [4];

  ram_access_ctrl_if bus ();

  ram_access_ctrl #(
    .WR_PULSE  (WR_PULSE),
    .RD_WAIT   (RD_WAIT),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .bus        (bus),
    .ram_clear_n(ram_clear_n),
    .ram_read   (ram_read),
    .ram_sel    (ram_sel),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural 4-byte RAM: clears while clear_n low, writes while read is low.
  always @(posedge clk) begin
    if (!ram_clear_n) ram_mem <= '{default: 8'h00};
    else if (!ram_read) ram_mem[ram_sel] <= ram_wdata;
  end
  assign ram_rdata = ram_mem[ram_sel];

  int n_cmp = 0, n_err = 0;
  int n_issued = 0, n_hs = 0, n_rsp = 0, n_aborted = 0;
  int cyc = 0, since_rel = 0, run = 0;

  typedef struct {
    int         due;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t       expq [$];
  exp_t       e;
  logic [7:0] ref_mem [4];
  bit   [3:0] ref_wr;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (clear) since_rel = 0;
    else if (since_rel < 1000) since_rel++;
  end

  // Reference model: every accepted request produces one response at a fixed latency.
  initial begin
    ref_mem = '{default: 8'h00};
    ref_wr  = '0;
    wr_sel  = '0;
    wr_data = '0;
    forever begin
      @(negedge clk);
      if (clear) begin
        check_eq("rst_clear_n", 32'(ram_clear_n), 0);
        check_eq("rst_ram_read", 32'(ram_read), 1);
        check_eq("rst_ram_sel", 32'(ram_sel), 0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 0);
        n_aborted += expq.size();
        expq.delete();
        ref_mem = '{default: 8'h00};
        ref_wr  = '0;
        run     = 0;
      end else begin
        if (expq.size() > 0 && expq[0].due < cyc) begin
          check_eq("rsp_missing_cycle", cyc, expq[0].due);
          void'(expq.pop_front());
        end
        if (bus.rsp_valid) begin
          n_rsp++;
          if (expq.size() == 0) begin
            check_eq("rsp_unexpected", 1, 0);
          end else begin
            e = expq.pop_front();
            check_eq("rsp_cycle", cyc, e.due);
            check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          end
        end
        check_eq("ram_clear_n", 32'(ram_clear_n), 32'(since_rel >= CLR_CYCLES));
        check_eq("req_ready", 32'(bus.req_ready),
                 32'(since_rel >= CLR_CYCLES && expq.size() == 0));
        if (bus.req_valid && bus.req_ready) begin
          n_hs++;
          if (bus.req_we) begin
            ref_mem[bus.req_addr] = bus.req_wdata;
            ref_wr[bus.req_addr]  = 1'b1;
            wr_sel  = bus.req_addr;
            wr_data = bus.req_wdata;
            expq.push_back('{due: cyc + WR_PULSE + 3, rdata: 8'h00, err: 1'b0});
          end else begin
            expq.push_back('{due: cyc + RD_WAIT + 1, rdata: ref_mem[bus.req_addr],
                             err: !ref_wr[bus.req_addr]});
          end
        end
        if (!ram_read) begin
          run++;
          check_eq("pulse_sel", 32'(ram_sel), 32'(wr_sel));
          check_eq("pulse_wdata", 32'(ram_wdata), 32'(wr_data));
        end else if (run > 0) begin
          check_eq("pulse_len", run, WR_PULSE);
          check_eq("hold_sel", 32'(ram_sel), 32'(wr_sel));
          check_eq("hold_wdata", 32'(ram_wdata), 32'(wr_data));
          run = 0;
        end
      end
    end
  end

  // Drive one request until accepted; optionally toggle junk on the bus while busy.
  task automatic do_req(input logic we, input logic [1:0] a, input logic [7:0] d, input bit noise);
    bit ok = 1'b0;
    int lat;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n_issued++;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      check_eq("accept_timeout", 0, 1);
      return;
    end
    if (noise) begin
      lat = we ? WR_PULSE + 3 : RD_WAIT + 1;
      for (int k = 1; k < lat; k++) begin
        bus.req_valid = 1'($urandom_range(1, 0));
        bus.req_we    = 1'($urandom_range(1, 0));
        bus.req_addr  = 2'($urandom_range(3, 0));
        bus.req_wdata = 8'($urandom_range(255, 0));
        @(posedge clk);
        #1;
      end
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;

    do_req(1'b1, 2'd0, 8'h11, 1'b0);
    do_req(1'b1, 2'd1, 8'h22, 1'b0);
    do_req(1'b1, 2'd2, 8'h44, 1'b0);
    do_req(1'b1, 2'd3, 8'h88, 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 2'(i), 8'h00, 1'b0);

    pulse_clear();
    do_req(1'b0, 2'd2, 8'h00, 1'b0);

    // Abort a write in the middle of its strobe.
    do_req(1'b1, 2'd1, 8'h22, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (!ram_read) found = 1'b1;
    end
    check_eq("abort_found_strobe", 32'(found), 1);
    #2;
    clear = 1'b1;
    #1;
    check_eq("abort_ram_read", 32'(ram_read), 1);
    check_eq("abort_clear_n", 32'(ram_clear_n), 0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    do_req(1'b0, 2'd1, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
             8'($urandom_range(255, 0)), ($urandom_range(3, 0) == 0));
      repeat ($urandom_range(2, 0) == 2 ? 1 : 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (WR_PULSE + RD_WAIT + 10) @(posedge clk);
    #1;
    check_eq("outstanding", expq.size(), 0);
    check_eq("accepted_vs_issued", n_hs, n_issued);
    check_eq("responses_vs_accepted", n_rsp + n_aborted, n_hs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter WR_PULSE, default 2, number of cycles the RAM write strobe (ram_read low) is held; legal range 1..15.
REQ-002 Parameter RD_WAIT, default 2, cycles between driving a read address and sampling RAM output; legal range 1..15.
REQ-003 Parameter CLR_CYCLES, default 4, cycles the RAM clear line is held active after reset; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  requester has a transaction.
REQ-007 req_ready  output  1  controller accepts a transaction this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  2  byte address 0..3.
REQ-010 req_wdata  input  8  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  8  read data; 0x00 for writes.
REQ-013 rsp_err  output  1  read of a never-written address.
REQ-014 ram_clear_n  output  1  to 4-byte RAM clear, active-low.
REQ-015 ram_read  output  1  to RAM read; 0 = write mode (decoder enabled), 1 = read mode.
REQ-016 ram_sel  output  2  to RAM select.
REQ-017 ram_wdata  output  8  to RAM data inputs.
REQ-018 ram_rdata  input  8  from RAM data outputs.

Function
REQ-019 FSM states SHALL be INIT, IDLE, WSET, WPULSE, WHOLD, RWAIT.
REQ-020 INIT: ram_clear_n=0 for CLR_CYCLES cycles, req_ready=0, then IDLE.
REQ-021 IDLE: req_ready=1; handshake = req_valid&req_ready on a clock edge; request fields registered at that edge.
REQ-022 Write path: WSET 1 cycle (ram_read=1, ram_sel/ram_wdata driven) -> WPULSE WR_PULSE cycles (ram_read=0) -> WHOLD 1 cycle (ram_read=1, sel/data unchanged) -> IDLE.
REQ-023 ram_sel and ram_wdata SHALL be stable from WSET through WHOLD; ram_read SHALL never be 0 outside WPULSE.
REQ-024 Read path: RWAIT RD_WAIT cycles (ram_read=1, ram_sel=addr); ram_rdata sampled at the edge ending the last RWAIT cycle -> IDLE.
REQ-025 Latency, handshake edge = cycle 0: write rsp_valid in cycle WR_PULSE+3; read rsp_valid in cycle RD_WAIT+1.
REQ-026 rsp_valid SHALL be high exactly one cycle, in the first IDLE cycle after completion; rsp_rdata/rsp_err valid only then, held until next completion.
REQ-027 A new request SHALL be accepted in the same IDLE cycle as rsp_valid (back-to-back, no bubble).
REQ-028 written[3:0] flag register: bit addr set at WHOLD; read with written[addr]=0 gives rsp_err=1 and the sampled data.
REQ-029 Write then read of same address back-to-back SHALL return the new data (write fully completes before read begins).
REQ-030 Counters SHALL be 4 bits and reload on each state entry; no wrap beyond parameter value.
REQ-031 req_valid outside IDLE SHALL be ignored; requester holds it until accepted.

Reset
REQ-032 clear=1 SHALL immediately force INIT, ram_clear_n=0, ram_read=1, ram_sel=00, ram_wdata=0x00, req_ready=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, written=0000.
REQ-033 Reset mid-write SHALL abort with ram_read=1 at once; no response for the aborted transaction.
REQ-034 After clear falls, INIT runs its full CLR_CYCLES count before IDLE.

Verification
REQ-035 Reset release -> ram_clear_n low exactly 4 cycles, req_ready rises cycle 5.
REQ-036 Write addr 0 data 0x11 -> ram_read low exactly 2 cycles with ram_sel=00, ram_wdata=0x11; rsp_valid cycle 5, rsp_rdata=0x00.
REQ-037 Writes 0x11,0x22,0x44,0x88 to addr 0..3, then reads 0..3 back-to-back -> rsp_rdata 0x11,0x22,0x44,0x88, rsp_err=0, each read rsp at cycle 3.
REQ-038 Read addr 2 after reset, no write -> rsp_err=1, rsp_rdata=0x00.
REQ-039 clear asserted during WPULSE of write 0x22 to addr 1 -> ram_read=1 same cycle, no rsp_valid; later read addr 1 -> rsp_err=1, 0x00.
REQ-040 req_valid toggled during busy states -> no extra acceptance; request count equals response count.
